dcache_controller: RTL and testbench

Sequencing controller for the processor's 16-set direct-mapped data cache. Sits between the core's memory stage and a single-ported backing memory: it performs tag lookup, services read misses by line fill, and writes stores through to memory, stalling the core while memory traffic is outstanding. It also provides a whole-cache invalidate and hit/miss statistics.

---
 rtl/dcache_controller.sv | 178 +++++++++++++++++
 tb/tb_dcache_controller.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_controller.sv
// Sequencing controller for a direct-mapped, one-word-line, write-through data cache
// with no allocation on store misses, line fill on load misses, whole-cache flush and hit/miss counters.
module dcache_controller #(
    parameter int SETS  = 16,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cpu_read,
    input  logic             cpu_write,
    input  logic [31:0]      cpu_address,
    input  logic [31:0]      cpu_writeData,
    input  logic             flush,
    output logic [31:0]      cpu_readData,
    output logic             cpu_done,
    output logic             busy,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_address,
    output logic [31:0]      mem_writeData,
    input  logic [31:0]      mem_readData,
    input  logic             mem_ack,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 29 - IDX_W;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WTHRU
    } state_t;

    state_t state;
    state_t stateNext;

    logic [SETS-1:0]  lineValid;
    logic [TAG_W-1:0] lineTag  [SETS];
    logic [31:0]      lineData [SETS];

    logic [IDX_W-1:0] reqIndex;
    logic [TAG_W-1:0] reqTag;
    logic [IDX_W-1:0] fillIndex;
    logic [TAG_W-1:0] fillTag;
    logic             lookupHit;

    logic doFlush;
    logic doLoadHit;
    logic doLoadMiss;
    logic doStore;
    logic doStoreHit;
    logic fillDone;
    logic storeDone;

    assign reqIndex  = cpu_address[IDX_W+2:3];
    assign reqTag    = cpu_address[31:IDX_W+3];
    // The outstanding miss address lives in mem_address, so the fill needs no extra latch.
    assign fillIndex = mem_address[IDX_W+2:3];
    assign fillTag   = mem_address[31:IDX_W+3];
    assign lookupHit = lineValid[reqIndex] && (lineTag[reqIndex] == reqTag);
    assign busy      = (state != IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        stateNext  = state;
        doFlush    = 1'b0;
        doLoadHit  = 1'b0;
        doLoadMiss = 1'b0;
        doStore    = 1'b0;
        doStoreHit = 1'b0;
        fillDone   = 1'b0;
        storeDone  = 1'b0;
        case (state)
            IDLE: begin
                if (flush) begin
                    doFlush = 1'b1;
                end else if (cpu_write) begin
                    doStore    = 1'b1;
                    doStoreHit = lookupHit;
                    stateNext  = WTHRU;
                end else if (cpu_read) begin
                    if (lookupHit) begin
                        doLoadHit = 1'b1;
                    end else begin
                        doLoadMiss = 1'b1;
                        stateNext  = FILL;
                    end
                end
            end
            FILL: begin
                if (mem_ack) begin
                    fillDone  = 1'b1;
                    stateNext = IDLE;
                end
            end
            WTHRU: begin
                if (mem_ack) begin
                    storeDone = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cpu_readData  <= '0;
            cpu_done      <= 1'b0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_address   <= '0;
            mem_writeData <= '0;
            hit_count     <= '0;
            miss_count    <= '0;
            lineValid     <= '0;
        end else begin
            cpu_done <= 1'b0;
            if (doFlush) begin
                lineValid <= '0;
            end
            if (doLoadHit) begin
                cpu_readData <= lineData[reqIndex];
                cpu_done     <= 1'b1;
                if (hit_count != '1) begin
                    hit_count <= hit_count + CNT_W'(1);
                end
            end
            if (doLoadMiss) begin
                if (miss_count != '1) begin
                    miss_count <= miss_count + CNT_W'(1);
                end
                mem_req     <= 1'b1;
                mem_we      <= 1'b0;
                mem_address <= cpu_address & 32'hFFFF_FFF8;
            end
            if (doStore) begin
                mem_req       <= 1'b1;
                mem_we        <= 1'b1;
                mem_address   <= cpu_address & 32'hFFFF_FFF8;
                mem_writeData <= cpu_writeData;
            end
            if (fillDone) begin
                lineValid[fillIndex] <= 1'b1;
                cpu_readData         <= mem_readData;
                cpu_done             <= 1'b1;
                mem_req              <= 1'b0;
            end
            if (storeDone) begin
                cpu_done <= 1'b1;
                mem_req  <= 1'b0;
                mem_we   <= 1'b0;
            end
        end
    end

    // NOTE: tag/data arrays are not reset; the valid bits alone decide whether a line is usable.
    always_ff @(posedge clock) begin
        if (fillDone) begin
            lineTag[fillIndex]  <= fillTag;
            lineData[fillIndex] <= mem_readData;
        end else if (doStoreHit) begin
            lineData[reqIndex] <= cpu_writeData;
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller: directed table, hand-written corner sequences,
// and randomized traffic against a set-indexed reference model of the cache.
module tb_dcache_controller;

    localparam int SETS    = 16;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clock = 1'b0;
    logic             reset;
    logic             cpu_read;
    logic             cpu_write;
    logic [31:0]      cpu_address;
    logic [31:0]      cpu_writeData;
    logic             flush;
    logic [31:0]      cpu_readData;
    logic             cpu_done;
    logic             busy;
    logic             mem_req;
    logic             mem_we;
    logic [31:0]      mem_address;
    logic [31:0]      mem_writeData;
    logic [31:0]      mem_readData;
    logic             mem_ack;
    logic [CNT_W-1:0] hit_count;
    logic [CNT_W-1:0] miss_count;

    always #5 clock = ~clock;

    dcache_controller #(.SETS(SETS), .CNT_W(CNT_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .cpu_read     (cpu_read),
        .cpu_write    (cpu_write),
        .cpu_address  (cpu_address),
        .cpu_writeData(cpu_writeData),
        .flush        (flush),
        .cpu_readData (cpu_readData),
        .cpu_done     (cpu_done),
        .busy         (busy),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_address  (mem_address),
        .mem_writeData(mem_writeData),
        .mem_readData (mem_readData),
        .mem_ack      (mem_ack),
        .hit_count    (hit_count),
        .miss_count   (miss_count)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: per set, which block it holds and that block's word.
    logic        mValid [SETS];
    logic [28:0] mBlock [SETS];
    logic [31:0] mData  [SETS];
    int          mHits;
    int          mMisses;

    typedef struct {
        logic        isWrite;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] fill;
        logic        expMem;
        logic        checkRd;
        logic [31:0] expRd;
        int          expHits;
        int          expMisses;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic modelReset();
        for (int i = 0; i < SETS; i++) mValid[i] = 1'b0;
        mHits   = 0;
        mMisses = 0;
    endtask

    task automatic modelFlush();
        for (int i = 0; i < SETS; i++) mValid[i] = 1'b0;
    endtask

    task automatic modelAccess(input logic isWrite, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] fillData, output logic expMem, output logic [31:0] expRd);
        logic [28:0] blk;
        int          set;
        logic        hit;
        blk   = addr[31:3];
        set   = int'(blk % SETS);
        hit   = mValid[set] && (mBlock[set] == blk);
        expRd = 32'h0;
        if (isWrite) begin
            expMem = 1'b1;
            if (hit) mData[set] = wdata;
        end else if (hit) begin
            expMem = 1'b0;
            expRd  = mData[set];
            if (mHits < CNT_MAX) mHits++;
        end else begin
            expMem      = 1'b1;
            expRd       = fillData;
            mValid[set] = 1'b1;
            mBlock[set] = blk;
            mData[set]  = fillData;
            if (mMisses < CNT_MAX) mMisses++;
        end
    endtask

    task automatic doReset();
        reset         = 1'b1;
        cpu_read      = 1'b0;
        cpu_write     = 1'b0;
        cpu_address   = '0;
        cpu_writeData = '0;
        flush         = 1'b0;
        mem_ack       = 1'b0;
        mem_readData  = '0;
        repeat (2) step();
        reset = 1'b0;
        modelReset();
    endtask

    // Drives one request to completion; memory acks after ackDelay wait cycles.
    task automatic transact(input logic isWrite, input logic bothHigh, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] fillData, input int ackDelay,
                            input logic strayAck, input logic flushInWait,
                            output logic wentMem, output logic done, output logic [31:0] rd,
                            output logic memWe, output logic [31:0] memAddr, output logic [31:0] memWd);
        cpu_write     = isWrite;
        cpu_read      = !isWrite || bothHigh;
        cpu_address   = addr;
        cpu_writeData = wdata;
        mem_ack       = strayAck;
        mem_readData  = $urandom;
        step();
        mem_ack = 1'b0;
        wentMem = mem_req;
        memWe   = mem_we;
        memAddr = mem_address;
        memWd   = mem_writeData;
        done    = cpu_done;
        if (mem_req) begin
            check("busy_in_mem", 32'(busy), 32'd1);
            for (int k = 0; k < ackDelay; k++) begin
                flush = flushInWait;
                step();
                flush = 1'b0;
                check("mem_req_held", 32'(mem_req), 32'd1);
                check("no_early_done", 32'(cpu_done), 32'd0);
            end
            mem_ack      = 1'b1;
            mem_readData = fillData;
            step();
            mem_ack = 1'b0;
            done    = cpu_done;
            check("mem_req_drop", 32'(mem_req), 32'd0);
        end
        rd        = cpu_readData;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
    endtask

    // One request checked against the reference model, then a check that cpu_done was a single pulse.
    task automatic runModel(input logic isWrite, input logic bothHigh, input logic [31:0] addr,
                            input logic [31:0] wdata, input int ackDelay, input logic strayAck,
                            input logic flushInWait);
        logic        expMem;
        logic [31:0] expRd;
        logic [31:0] fillData;
        logic        wentMem, done, memWe;
        logic [31:0] rd, memAddr, memWd;
        fillData = $urandom;
        modelAccess(isWrite, addr, wdata, fillData, expMem, expRd);
        transact(isWrite, bothHigh, addr, wdata, fillData, ackDelay, strayAck, flushInWait,
                 wentMem, done, rd, memWe, memAddr, memWd);
        check("done", 32'(done), 32'd1);
        check("went_mem", 32'(wentMem), 32'(expMem));
        if (expMem) begin
            check("mem_we", 32'(memWe), 32'(isWrite));
            check("mem_address", memAddr, addr & 32'hFFFF_FFF8);
        end
        if (isWrite) check("mem_writeData", memWd, wdata);
        else check("read_data", rd, expRd);
        check("hit_count", 32'(hit_count), 32'(mHits));
        check("miss_count", 32'(miss_count), 32'(mMisses));
        step();
        check("done_pulse", 32'(cpu_done), 32'd0);
    endtask

    initial begin
        logic        wentMem, done, memWe, expMemUnused;
        logic [31:0] rd, memAddr, memWd, expRdUnused;

        vecs[0] = '{1'b0, 32'h1008, 32'h0,         32'h0101_0101, 1'b1, 1'b1, 32'h0101_0101, 0, 1};
        vecs[1] = '{1'b0, 32'h1008, 32'h0,         32'h0,         1'b0, 1'b1, 32'h0101_0101, 1, 1};
        vecs[2] = '{1'b1, 32'h1008, 32'hFADE_CAFE, 32'h0,         1'b1, 1'b0, 32'h0,         1, 1};
        vecs[3] = '{1'b0, 32'h1008, 32'h0,         32'h0,         1'b0, 1'b1, 32'hFADE_CAFE, 2, 1};
        vecs[4] = '{1'b1, 32'h2010, 32'h1234_5678, 32'h0,         1'b1, 1'b0, 32'h0,         2, 1};
        vecs[5] = '{1'b0, 32'h2010, 32'h0,         32'hAAAA_0001, 1'b1, 1'b1, 32'hAAAA_0001, 2, 2};
        vecs[6] = '{1'b0, 32'h1088, 32'h0,         32'h0BAD_F00D, 1'b1, 1'b1, 32'h0BAD_F00D, 2, 3};
        vecs[7] = '{1'b0, 32'h1008, 32'h0,         32'h1111_2222, 1'b1, 1'b1, 32'h1111_2222, 2, 3};
        vecs[8] = '{1'b0, 32'h1008, 32'h0,         32'h0,         1'b0, 1'b1, 32'h1111_2222, 3, 3};
        vecs[9] = '{1'b0, 32'h1008, 32'h0,         32'h0,         1'b0, 1'b1, 32'h1111_2222, 3, 3};

        doReset();
        check("rst_readData", cpu_readData, 32'h0);
        check("rst_done", 32'(cpu_done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_address", mem_address, 32'h0);
        check("rst_mem_writeData", mem_writeData, 32'h0);
        check("rst_hits", 32'(hit_count), 32'd0);
        check("rst_misses", 32'(miss_count), 32'd0);

        // Directed table: fill, hit, store-through, no-allocate, conflict, counter saturation.
        foreach (vecs[i]) begin
            transact(vecs[i].isWrite, 1'b0, vecs[i].addr, vecs[i].wdata, vecs[i].fill, 1, 1'b0, 1'b0,
                     wentMem, done, rd, memWe, memAddr, memWd);
            modelAccess(vecs[i].isWrite, vecs[i].addr, vecs[i].wdata, vecs[i].fill, expMemUnused, expRdUnused);
            check($sformatf("vec%0d_done", i), 32'(done), 32'd1);
            check($sformatf("vec%0d_mem", i), 32'(wentMem), 32'(vecs[i].expMem));
            if (wentMem) begin
                check($sformatf("vec%0d_we", i), 32'(memWe), 32'(vecs[i].isWrite));
                check($sformatf("vec%0d_addr", i), memAddr, vecs[i].addr & 32'hFFFF_FFF8);
            end
            if (vecs[i].isWrite) check($sformatf("vec%0d_wdata", i), memWd, vecs[i].wdata);
            if (vecs[i].checkRd) check($sformatf("vec%0d_rd", i), rd, vecs[i].expRd);
            check($sformatf("vec%0d_hits", i), 32'(hit_count), 32'(vecs[i].expHits));
            check($sformatf("vec%0d_misses", i), 32'(miss_count), 32'(vecs[i].expMisses));
        end

        // Flush in IDLE wins over a concurrent load.
        flush       = 1'b1;
        cpu_read    = 1'b1;
        cpu_address = 32'h1008;
        step();
        flush    = 1'b0;
        cpu_read = 1'b0;
        modelFlush();
        check("flush_no_done", 32'(cpu_done), 32'd0);
        check("flush_no_req", 32'(mem_req), 32'd0);
        check("flush_hits", 32'(hit_count), 32'd3);
        runModel(1'b0, 1'b0, 32'h1008, 32'h0, 1, 1'b0, 1'b0);

        // Flush while FILL is outstanding must not invalidate anything.
        runModel(1'b0, 1'b0, 32'h1088, 32'h0, 2, 1'b0, 1'b1);
        runModel(1'b0, 1'b0, 32'h1088, 32'h0, 0, 1'b0, 1'b0);

        // Both read and write high is a store.
        runModel(1'b1, 1'b1, 32'h1088, 32'hC0FF_EE00, 0, 1'b0, 1'b0);
        runModel(1'b0, 1'b0, 32'h1088, 32'h0, 0, 1'b0, 1'b0);

        // Reset during FILL: mem_req drops without waiting for a clock, and no fill happens.
        cpu_read    = 1'b1;
        cpu_address = 32'h3030;
        step();
        check("pre_reset_req", 32'(mem_req), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("async_req_drop", 32'(mem_req), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_hits", 32'(hit_count), 32'd0);
        check("async_misses", 32'(miss_count), 32'd0);
        cpu_read     = 1'b0;
        mem_ack      = 1'b1;
        mem_readData = 32'hDEAD_BEEF;
        step();
        mem_ack = 1'b0;
        reset   = 1'b0;
        check("reset_no_done", 32'(cpu_done), 32'd0);
        modelReset();
        runModel(1'b0, 1'b0, 32'h3030, 32'h0, 1, 1'b0, 1'b0);
        runModel(1'b0, 1'b0, 32'h1008, 32'h0, 0, 1'b0, 1'b0);

        // Randomized traffic over 3 tags x 16 sets to provoke hits, misses and conflicts.
        doReset();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                flush = 1'b1;
                step();
                flush = 1'b0;
                modelFlush();
                check("rnd_flush_done", 32'(cpu_done), 32'd0);
            end else begin
                logic [31:0] addr;
                addr = (32'($urandom_range(0, 2)) << 7) | (32'($urandom_range(0, 15)) << 3)
                     | 32'($urandom_range(0, 7)) | 32'h4000_0000;
                runModel(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0), addr, $urandom,
                         int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
